// File: rtl/arm_decode_stage.sv
// Registered ARM decode stage: cracks instruction words into datapath controls and queues the
// decoded records in a small FIFO. Optional macro COND_ARM_EVAL_EN enables condition evaluation.
module arm_decode_stage #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned SHOP_W = 12,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    input  logic [3:0]                 flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 opcode,
    output logic [REG_W-1:0]           ra,
    output logic [REG_W-1:0]           rb,
    output logic [REG_W-1:0]           rc,
    output logic [SHOP_W-1:0]          shifter_operand,
    output logic                       shifter_en,
    output logic                       rotator_en,
    output logic                       sel,
    output logic                       regfile_en,
    output logic                       mem_en,
    output logic                       mem_load,
    output logic                       branch_en,
    output logic                       link,
    output logic [23:0]                branch_offset,
    output logic                       s_bit,
    output logic                       undef,
    output logic                       cond_fail,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [REG_W-1:0]  rc;
        logic [SHOP_W-1:0] shop;
        logic              shifter_en;
        logic              rotator_en;
        logic              sel;
        logic              regfile_en;
        logic              mem_en;
        logic              mem_load;
        logic              branch_en;
        logic              link;
        logic [23:0]       branch_offset;
        logic              s_bit;
        logic              undef;
        logic              cond_fail;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    rec_t             dec;
    rec_t             head;
    logic             push, pop, empty;
    logic [2:0]       fmt;

`ifdef COND_ARM_EVAL_EN
    // flags = {N, Z, C, V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'ha:    cond_pass = (n == v);
            4'hb:    cond_pass = (n != v);
            4'hc:    cond_pass = !z && (n == v);
            4'hd:    cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction
`else
    logic unused_cond;
    assign unused_cond = ^{flags, instruction[31:28]};
`endif

    assign fmt = instruction[27:25];

    always_comb begin
        dec               = '0;
        dec.ra            = instruction[16 +: REG_W];
        dec.rb            = instruction[0 +: REG_W];
        dec.rc            = instruction[12 +: REG_W];
        dec.shop          = instruction[SHOP_W-1:0];
        dec.branch_offset = instruction[23:0];
        case (fmt)
            3'b000, 3'b001: begin
                dec.shifter_en = (fmt == 3'b000);
                dec.rotator_en = (fmt == 3'b001);
                dec.sel        = (fmt == 3'b000);
                dec.opcode     = instruction[24:21];
                dec.s_bit      = instruction[20];
                // TST/TEQ/CMP/CMN only set flags and never write back
                dec.regfile_en = (instruction[24:23] != 2'b10);
            end
            3'b010, 3'b011: begin
                if (fmt == 3'b011 && instruction[4]) begin
                    dec.undef = 1'b1;
                end else begin
                    dec.mem_en     = 1'b1;
                    dec.mem_load   = instruction[20];
                    dec.regfile_en = instruction[20];
                    dec.sel        = (fmt == 3'b011);
                    dec.shifter_en = (fmt == 3'b011);
                    dec.opcode     = 4'b0100;
                end
            end
            3'b101: begin
                dec.branch_en  = 1'b1;
                dec.link       = instruction[24];
                dec.regfile_en = instruction[24];
                dec.rc         = REG_W'(4'he);
            end
            default: dec.undef = 1'b1;
        endcase
`ifdef COND_ARM_EVAL_EN
        if (instruction[31:28] == 4'hf) begin
            dec.undef = 1'b1;
        end else if (!cond_pass(instruction[31:28], flags)) begin
            dec.cond_fail = 1'b1;
        end
`endif
        if (dec.undef || dec.cond_fail) begin
            dec.shifter_en = 1'b0;
            dec.rotator_en = 1'b0;
            dec.sel        = 1'b0;
            dec.regfile_en = 1'b0;
            dec.mem_en     = 1'b0;
            dec.mem_load   = 1'b0;
            dec.branch_en  = 1'b0;
            dec.link       = 1'b0;
        end
    end

    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign opcode          = head.opcode;
    assign ra              = head.ra;
    assign rb              = head.rb;
    assign rc              = head.rc;
    assign shifter_operand = head.shop;
    assign shifter_en      = head.shifter_en;
    assign rotator_en      = head.rotator_en;
    assign sel             = head.sel;
    assign regfile_en      = head.regfile_en;
    assign mem_en          = head.mem_en;
    assign mem_load        = head.mem_load;
    assign branch_en       = head.branch_en;
    assign link            = head.link;
    assign branch_offset   = head.branch_offset;
    assign s_bit           = head.s_bit;
    assign undef           = head.undef;
    assign cond_fail       = head.cond_fail;
    assign count           = count_q;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Scoreboard bench for arm_decode_stage: the driver queues hand-computed records, a monitor
// pops and compares them whenever a record is handed on.
module tb_arm_decode_stage;

    // {shifter, rotator, sel, regfile, mem, load, branch, link}
    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [11:0] shop;
        logic [7:0]  en;
        logic [23:0] off;
        logic        s_bit;
        logic        undef;
        logic        cond_fail;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic [3:0]  opcode, ra, rb, rc;
    logic [11:0] shifter_operand;
    logic        shifter_en, rotator_en, sel, regfile_en, mem_en, mem_load, branch_en, link;
    logic [23:0] branch_offset;
    logic        s_bit, undef, cond_fail;
    logic [1:0]  count;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    rec_t got;

    arm_decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flags(flags), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .shifter_operand(shifter_operand),
        .shifter_en(shifter_en), .rotator_en(rotator_en), .sel(sel), .regfile_en(regfile_en),
        .mem_en(mem_en), .mem_load(mem_load), .branch_en(branch_en), .link(link),
        .branch_offset(branch_offset), .s_bit(s_bit), .undef(undef), .cond_fail(cond_fail),
        .count(count)
    );

    always #5 clk = ~clk;

    assign got = {opcode, ra, rb, rc, shifter_operand,
                  {shifter_en, rotator_en, sel, regfile_en, mem_en, mem_load, branch_en, link},
                  branch_offset, s_bit, undef, cond_fail};

    function automatic rec_t mk(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [11:0] sh,
                                input logic [7:0] en, input logic [23:0] off,
                                input logic s, input logic u, input logic cf);
        mk = {op, a, b, c, sh, en, off, s, u, cf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor samples mid-cycle; inputs only change just after the rising edge
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 64'(got), 64'h0);
                    if (got == '0) begin
                        errors++;
                        $display("FAIL unexpected_record: got record with empty scoreboard");
                    end
                end else begin
                    check("record", 64'(got), 64'(exp_q.pop_front()));
                end
            end else if (!out_valid) begin
                check("empty_fields_zero", 64'(got), 64'h0);
            end
        end
    end

    task automatic send(input logic [31:0] w, input rec_t e);
        int n = 0;
        in_valid    = 1'b1;
        instruction = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'h1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; flags = 4'h0;
        tick();
        reset = 1'b0;
        check("reset_count", 64'(count), 64'h0);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check("reset_fields", 64'(got), 64'h0);

        // Single records with consumer ready
        out_ready = 1'b1;
        send(32'hE0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_0000, 24'h812003,
                              1'b0, 1'b0, 1'b0));
        send(32'hE3510005, mk(4'b1010, 4'd1, 4'd5, 4'd0, 12'h005, 8'b0100_0000, 24'h510005,
                              1'b1, 1'b0, 1'b0));
        send(32'hE5912004, mk(4'b0100, 4'd1, 4'd4, 4'd2, 12'h004, 8'b0001_1100, 24'h912004,
                              1'b0, 1'b0, 1'b0));
        send(32'hEB000010, mk(4'b0000, 4'd0, 4'd0, 4'he, 12'h010, 8'b0001_0011, 24'h000010,
                              1'b0, 1'b0, 1'b0));
        send(32'hE5812000, mk(4'b0100, 4'd1, 4'd0, 4'd2, 12'h000, 8'b0000_1000, 24'h812000,
                              1'b0, 1'b0, 1'b0));
        send(32'hE7912003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_1100, 24'h912003,
                              1'b0, 1'b0, 1'b0));
        send(32'hE7912014, mk(4'b0000, 4'd1, 4'd4, 4'd2, 12'h014, 8'b0000_0000, 24'h912014,
                              1'b0, 1'b1, 1'b0));
        send(32'hE8000000, mk(4'b0000, 4'd0, 4'd0, 4'd0, 12'h000, 8'b0000_0000, 24'h000000,
                              1'b0, 1'b1, 1'b0));
        send(32'hEA000005, mk(4'b0000, 4'd0, 4'd5, 4'he, 12'h005, 8'b0000_0010, 24'h000005,
                              1'b0, 1'b0, 1'b0));
        drain();

        // Backpressure: third word stalls until the consumer pops
        out_ready = 1'b0;
        fork
            begin
                send(32'hE0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_0000,
                                      24'h812003, 1'b0, 1'b0, 1'b0));
                send(32'hE3510005, mk(4'b1010, 4'd1, 4'd5, 4'd0, 12'h005, 8'b0100_0000,
                                      24'h510005, 1'b1, 1'b0, 1'b0));
                send(32'hEB000010, mk(4'b0000, 4'd0, 4'd0, 4'he, 12'h010, 8'b0001_0011,
                                      24'h000010, 1'b0, 1'b0, 1'b0));
            end
            begin
                repeat (4) @(negedge clk);
                check("full_count", 64'(count), 64'h2);
                check("full_in_ready", 64'(in_ready), 64'h0);
                tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush at count=1 with a simultaneous push: both are lost
        out_ready = 1'b0;
        send(32'hE0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_0000, 24'h812003,
                              1'b0, 1'b0, 1'b0));
        check("pre_flush_count", 64'(count), 64'h1);
        flush = 1'b1; in_valid = 1'b1; instruction = 32'hE5912004;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush1_count", 64'(count), 64'h0);
        check("flush1_out_valid", 64'(out_valid), 64'h0);
        tick();
        check("flush1_push_lost", 64'(count), 64'h0);

        // Flush when full
        send(32'hE0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_0000, 24'h812003,
                              1'b0, 1'b0, 1'b0));
        send(32'hE3510005, mk(4'b1010, 4'd1, 4'd5, 4'd0, 12'h005, 8'b0100_0000, 24'h510005,
                              1'b1, 1'b0, 1'b0));
        check("pre_flush2_count", 64'(count), 64'h2);
        flush = 1'b1; in_valid = 1'b1; instruction = 32'hEB000010;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush2_count", 64'(count), 64'h0);
        check("flush2_in_ready", 64'(in_ready), 64'h1);

        // Reset mid-stream discards the buffered record
        send(32'hE5912004, mk(4'b0100, 4'd1, 4'd4, 4'd2, 12'h004, 8'b0001_1100, 24'h912004,
                              1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midreset_count", 64'(count), 64'h0);
        check("midreset_fields", 64'(got), 64'h0);

        // Condition field handling
        out_ready = 1'b1;
        flags = 4'h0;
`ifdef COND_ARM_EVAL_EN
        send(32'h0A000001, mk(4'b0000, 4'd0, 4'd1, 4'he, 12'h001, 8'b0000_0000, 24'h000001,
                              1'b0, 1'b0, 1'b1));
        flags = 4'b0100;
        send(32'h0A000001, mk(4'b0000, 4'd0, 4'd1, 4'he, 12'h001, 8'b0000_0010, 24'h000001,
                              1'b0, 1'b0, 1'b0));
        send(32'hF0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b0000_0000, 24'h812003,
                              1'b0, 1'b1, 1'b0));
`else
        send(32'h0A000001, mk(4'b0000, 4'd0, 4'd1, 4'he, 12'h001, 8'b0000_0010, 24'h000001,
                              1'b0, 1'b0, 1'b0));
        send(32'hF0812003, mk(4'b0100, 4'd1, 4'd3, 4'd2, 12'h003, 8'b1011_0000, 24'h812003,
                              1'b0, 1'b0, 1'b0));
`endif
        drain();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
